// File: rtl/pe_imem_loader_pkg.sv
// rtl/pe_imem_loader_pkg.sv - shared widths, loader states and checksum rotate for the PE imem loader
package pe_imem_loader_pkg;

    localparam int PE_INS_WIDTH        = 24;
    localparam int PE_IMEM_WIDTH       = 28;
    localparam int PE_IMEM_ADDR_BITS   = 13;
    localparam int PE_LOADER_CNT_BITS  = 14;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WRITE        = 3'd1,
        ST_VERIFY_ISSUE = 3'd2,
        ST_VERIFY_DRAIN = 3'd3,
        ST_DONE         = 3'd4
    } loader_state_e;

    function automatic logic [PE_IMEM_WIDTH-1:0] rotl1(input logic [PE_IMEM_WIDTH-1:0] v);
        return {v[PE_IMEM_WIDTH-2:0], v[PE_IMEM_WIDTH-1]};
    endfunction

endpackage

// File: rtl/pe_imem_cksum.sv
// rtl/pe_imem_cksum.sv - rotate-xor checksum accumulator with clear and enable
module pe_imem_cksum
    import pe_imem_loader_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic [PE_IMEM_WIDTH-1:0] data_i,
    output logic [PE_IMEM_WIDTH-1:0] sum_o,
    output logic [PE_IMEM_WIDTH-1:0] sum_d_o
);

    logic [PE_IMEM_WIDTH-1:0] sum_q;
    logic [PE_IMEM_WIDTH-1:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (en_i) begin
            sum_d = rotl1(sum_q) ^ data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    // The next value is exported so the final read can be compared in the cycle it is captured.
    assign sum_o   = sum_q;
    assign sum_d_o = sum_d;

endmodule

// File: rtl/pe_imem_loader.sv
// rtl/pe_imem_loader.sv - loads instruction words into PE imem port A with optional checksum read-back
module pe_imem_loader
    import pe_imem_loader_pkg::*;
#(
    parameter int RAM_WIDTH     = PE_IMEM_WIDTH,
    parameter int RAM_ADDR_BITS = PE_IMEM_ADDR_BITS,
    parameter int CNT_BITS      = PE_LOADER_CNT_BITS
) (
    input  logic                     iClk,
    input  logic                     iReset,
    input  logic                     iCmd_Valid,
    output logic                     oCmd_Ready,
    input  logic [RAM_ADDR_BITS-1:0] iCmd_Start_Addr,
    input  logic [CNT_BITS-1:0]      iCmd_Count,
    input  logic                     iCmd_Verify,
    input  logic                     iData_Valid,
    output logic                     oData_Ready,
    input  logic [RAM_WIDTH-1:0]     iData,
    output logic                     oBus_Valid,
    output logic [RAM_ADDR_BITS-1:0] oBus_Address,
    output logic [RAM_WIDTH-1:0]     oBus_Write_Data,
    output logic                     oBus_Write_Enable,
    input  logic [RAM_WIDTH-1:0]     iBus_Read_Data,
    output logic                     oCore_Stall,
    output logic                     oDone,
    output logic                     oError
);

    loader_state_e            state_q, state_d;
    logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [RAM_ADDR_BITS-1:0] start_q, start_d;
    logic [CNT_BITS-1:0]      remain_q, remain_d;
    logic [CNT_BITS-1:0]      count_q, count_d;
    logic                     verify_q, verify_d;
    logic                     err_q, err_d;
    logic                     issue_q;
    logic                     sum_clr;
    logic                     beat;
    logic                     rd_issue;
    logic [RAM_WIDTH-1:0]     wsum;
    logic [RAM_WIDTH-1:0]     wsum_d_unused;
    logic [RAM_WIDTH-1:0]     rsum_unused;
    logic [RAM_WIDTH-1:0]     rsum_d;

    assign beat     = (state_q == ST_WRITE) && iData_Valid;
    assign rd_issue = (state_q == ST_VERIFY_ISSUE);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        start_d  = start_q;
        remain_d = remain_q;
        count_d  = count_q;
        verify_d = verify_q;
        err_d    = err_q;
        sum_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iCmd_Valid) begin
                    start_d  = iCmd_Start_Addr;
                    count_d  = iCmd_Count;
                    verify_d = iCmd_Verify;
                    addr_d   = iCmd_Start_Addr;
                    remain_d = iCmd_Count;
                    err_d    = 1'b0;
                    sum_clr  = 1'b1;
                    state_d  = (iCmd_Count == '0) ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (beat) begin
                    addr_d   = addr_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                    if (remain_q == CNT_BITS'(1)) begin
                        if (verify_q) begin
                            // Rewind for the read-back pass over the same region.
                            addr_d   = start_q;
                            remain_d = count_q;
                            state_d  = ST_VERIFY_ISSUE;
                        end else begin
                            state_d  = ST_DONE;
                        end
                    end
                end
            end
            ST_VERIFY_ISSUE: begin
                addr_d   = addr_q + 1'b1;
                remain_d = remain_q - 1'b1;
                if (remain_q == CNT_BITS'(1)) begin
                    state_d = ST_VERIFY_DRAIN;
                end
            end
            ST_VERIFY_DRAIN: begin
                if (rsum_d != wsum) begin
                    err_d = 1'b1;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            start_q  <= '0;
            remain_q <= '0;
            count_q  <= '0;
            verify_q <= 1'b0;
            err_q    <= 1'b0;
            issue_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            start_q  <= start_d;
            remain_q <= remain_d;
            count_q  <= count_d;
            verify_q <= verify_d;
            err_q    <= err_d;
            issue_q  <= rd_issue;
        end
    end

    pe_imem_cksum u_wsum (
        .clk_i   (iClk),
        .rst_i   (iReset),
        .clr_i   (sum_clr),
        .en_i    (beat),
        .data_i  (iData),
        .sum_o   (wsum),
        .sum_d_o (wsum_d_unused)
    );

    // Read data lags its issue by one cycle, so issue_q qualifies the capture.
    pe_imem_cksum u_rsum (
        .clk_i   (iClk),
        .rst_i   (iReset),
        .clr_i   (sum_clr),
        .en_i    (issue_q),
        .data_i  (iBus_Read_Data),
        .sum_o   (rsum_unused),
        .sum_d_o (rsum_d)
    );

    assign oCmd_Ready        = (state_q == ST_IDLE);
    assign oData_Ready       = (state_q == ST_WRITE);
    assign oBus_Valid        = beat || rd_issue;
    assign oBus_Write_Enable = beat;
    assign oBus_Address      = oBus_Valid ? addr_q : '0;
    assign oBus_Write_Data   = beat ? iData : '0;
    assign oCore_Stall       = (state_q != ST_IDLE);
    assign oDone             = (state_q == ST_DONE);
    assign oError            = err_q;

endmodule

// File: tb/tb_pe_imem_loader.sv
// tb/tb_pe_imem_loader.sv - self-checking bench for pe_imem_loader with an imem port A model
module tb_pe_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [12:0] cmd_start;
    logic [13:0] cmd_count;
    logic        cmd_verify;
    logic        data_valid;
    logic        data_ready;
    logic [27:0] data;
    logic        bus_valid;
    logic [12:0] bus_addr;
    logic [27:0] bus_wdata;
    logic        bus_we;
    logic [27:0] bus_rdata;
    logic        core_stall;
    logic        done;
    logic        error;

    int tests = 0;
    int fails = 0;

    logic [27:0] mem [0:8191];
    logic [27:0] stuck_mask = '0;
    logic [40:0] wq [$];
    logic [12:0] rq [$];

    always #5 clk = ~clk;

    pe_imem_loader dut (
        .iClk              (clk),
        .iReset            (rst),
        .iCmd_Valid        (cmd_valid),
        .oCmd_Ready        (cmd_ready),
        .iCmd_Start_Addr   (cmd_start),
        .iCmd_Count        (cmd_count),
        .iCmd_Verify       (cmd_verify),
        .iData_Valid       (data_valid),
        .oData_Ready       (data_ready),
        .iData             (data),
        .oBus_Valid        (bus_valid),
        .oBus_Address      (bus_addr),
        .oBus_Write_Data   (bus_wdata),
        .oBus_Write_Enable (bus_we),
        .iBus_Read_Data    (bus_rdata),
        .oCore_Stall       (core_stall),
        .oDone             (done),
        .oError            (error)
    );

    always @(posedge clk) begin
        if (bus_valid && bus_we) mem[bus_addr] <= bus_wdata;
        if (bus_valid && !bus_we) bus_rdata <= mem[bus_addr] | stuck_mask;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_we && !bus_valid) check("we_without_valid", 1, 0);
            if (bus_valid && bus_we) begin
                if (wq.size() == 0) check("unexpected_write", {bus_addr, bus_wdata}, 0);
                else check("write_addr_data", {bus_addr, bus_wdata}, wq.pop_front());
            end
            if (bus_valid && !bus_we) begin
                if (rq.size() == 0) check("unexpected_read", bus_addr, 0);
                else check("read_addr", bus_addr, rq.pop_front());
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        check(name, {cmd_ready, data_ready, bus_valid, bus_addr, bus_wdata, bus_we, core_stall, done, error},
              {1'b1, 1'b0, 1'b0, 13'd0, 28'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    // Entered shortly after a rising edge with the loader idle; returns the same way.
    task automatic run_cmd(input logic [12:0] start, input logic [13:0] cnt, input bit ver,
                           input int gap, input bit seq, input bit exp_err);
        logic [27:0] words [$];
        int sent = 0;
        int last = 0;
        int k;
        int done_k = -1;
        int exp_done;
        logic [12:0] a;
        assert (cnt <= 14'd8192) else $error("illegal command count %0d", cnt);
        for (int i = 0; i < int'(cnt); i++) words.push_back(seq ? 28'(i + 1) : 28'($urandom));
        cmd_start = start; cmd_count = cnt; cmd_verify = ver; cmd_valid = 1'b1;
        @(negedge clk);
        check("cmd_ready_at_accept", cmd_ready, 1);
        check("stall_before_accept", core_stall, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (ver) for (int i = 0; i < int'(cnt); i++) rq.push_back(start + 13'(i));
        for (k = 1; k < 4000; k++) begin
            if (sent < int'(cnt)) begin
                if (gap == 0 || $urandom_range(99) >= gap) begin
                    data_valid = 1'b1;
                    data = words[sent];
                    wq.push_back({start + 13'(sent), words[sent]});
                    sent++;
                    if (sent == int'(cnt)) last = k;
                end else begin
                    data_valid = 1'b0;
                end
            end else if (cnt != 0 && k == last + 1) begin
                data_valid = 1'b1;
                data = 28'hABCDEF0;
            end else begin
                data_valid = 1'b0;
            end
            @(negedge clk);
            if (k == 1) check("error_cleared_on_accept", error, 0);
            if (cnt != 0 && sent == int'(cnt) && k == last + 1) check("data_ready_after_last", data_ready, 0);
            check("stall_while_busy", core_stall, 1);
            if (done) begin
                done_k = k;
                break;
            end
            @(posedge clk); #1;
        end
        data_valid = 1'b0;
        exp_done = (cnt == 0) ? 1 : last + 1 + (ver ? int'(cnt) + 1 : 0);
        check("done_cycle", done_k, exp_done);
        check("error_at_done", error, exp_err);
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_after_done", {core_stall, done, cmd_ready}, 3'b001);
        check("queues_drained", wq.size() + rq.size(), 0);
        for (int i = 0; i < int'(cnt); i++) begin
            a = start + 13'(i);
            check("core_port_readback", mem[a], words[i]);
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [12:0] start;
        logic [13:0] cnt;
        bit          ver;
        int          gap;
        logic [27:0] stuck;
        bit          exp_err;
        bit          seq;
    } vec_t;

    vec_t vecs [6];
    bit   last_err;

    initial begin
        vecs[0] = '{13'h0010, 14'd4,  1'b0, 0,  28'h0,       1'b0, 1'b1};
        vecs[1] = '{13'h0010, 14'd4,  1'b1, 0,  28'h0,       1'b0, 1'b1};
        vecs[2] = '{13'h0010, 14'd4,  1'b1, 0,  28'h0100000, 1'b1, 1'b1};
        vecs[3] = '{13'h1FFE, 14'd4,  1'b0, 0,  28'h0,       1'b0, 1'b1};
        vecs[4] = '{13'h0100, 14'd0,  1'b0, 0,  28'h0,       1'b0, 1'b1};
        vecs[5] = '{13'h0200, 14'd64, 1'b1, 50, 28'h0,       1'b0, 1'b0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_start = '0; cmd_count = '0; cmd_verify = 1'b0;
        data_valid = 1'b0; data = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("reset_outputs");
        @(posedge clk); #1;
        rst = 1'b0;
        last_err = 1'b0;

        for (int v = 0; v < 6; v++) begin
            repeat (2) begin
                @(negedge clk);
                check("error_held_idle", error, last_err);
                @(posedge clk); #1;
            end
            stuck_mask = vecs[v].stuck;
            run_cmd(vecs[v].start, vecs[v].cnt, vecs[v].ver, vecs[v].gap, vecs[v].seq, vecs[v].exp_err);
            last_err = vecs[v].exp_err;
        end
        stuck_mask = '0;

        // Reset lands in WRITE after two of eight words.
        cmd_start = 13'h0300; cmd_count = 14'd8; cmd_verify = 1'b0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data_valid = 1'b1;
            data = 28'(32'h0A00_0000 + i);
            wq.push_back({13'h0300 + 13'(i), data});
            @(negedge clk);
            check("midwrite_no_done", done, 0);
            @(posedge clk); #1;
        end
        data_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("reset_cycle_no_done", done, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("midwrite_reset_outputs");
        @(posedge clk); #1;
        rst = 1'b0;
        run_cmd(13'h0300, 14'd2, 1'b0, 0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
